// File: rtl/dma_priority_arbiter.sv
// dma_priority_arbiter: request-side stage in front of the DMA timing FSM.
// It synchronises and polarity-corrects DREQ, applies the mask and software
// requests, picks a winner with fixed or rotating priority, holds that grant
// for the whole service, and drives the DACK pins while the FSM asks for it.
module dma_priority_arbiter #(
    parameter int NCH = 4
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic [NCH-1:0] DREQ,
    input  logic [7:0]     commandReg,
    input  logic [NCH-1:0] maskReg,
    input  logic [NCH-1:0] requestReg,
    input  logic           IDLE_CYCLE,
    input  logic           validDACK,
    input  logic           serviceDone,
    output logic [NCH-1:0] VALID_DREQ,
    output logic [NCH-1:0] DACK,
    output logic [1:0]     activeCh,
    output logic [NCH-1:0] reqStatus
);

    typedef enum logic {
        ArbIdle = 1'b0,
        ArbHold = 1'b1
    } arbState_t;

    arbState_t      state, stateNext;
    logic [NCH-1:0] dreqS;
    logic [NCH-1:0] eff;
    logic [NCH-1:0] validNext;
    logic [NCH-1:0] dackNext;
    logic [1:0]     lowPri, lowPriNext;
    logic [1:0]     activeChNext;
    logic [1:0]     win;
    logic [1:0]     idx;
    logic           winFound;
    logic           grantHeld;
    logic           arbGo;

    // Command bit aliases
    logic ctrlDisable, rotatePri, dreqActLow, dackActHigh;
    assign ctrlDisable = commandReg[2];
    assign rotatePri   = commandReg[4];
    assign dreqActLow  = commandReg[6];
    assign dackActHigh = commandReg[7];

    assign grantHeld = (state == ArbHold);

    // Software requests bypass the mask; hardware requests do not.
    assign eff = (dreqS & ~maskReg) | requestReg;

    // Single-stage DREQ synchroniser with polarity folded in ahead of the
    // flop, plus the status request bits (mask deliberately ignored there).
    always_ff @(posedge CLK) begin
        if (RESET) begin
            dreqS     <= '0;
            reqStatus <= '0;
        end else begin
            dreqS     <= DREQ ^ {NCH{dreqActLow}};
            reqStatus <= dreqS | requestReg;
        end
    end

    // Winner search: fixed scans up from ch0, rotating scans up from the
    // channel after the last one serviced, wrapping 3 -> 0.
    always_comb begin
        win      = '0;
        winFound = 1'b0;
        idx      = '0;
        for (int i = 0; i < NCH; i++) begin
            if (rotatePri) idx = lowPri + 2'(i + 1);
            else           idx = 2'(i);
            if (!winFound && eff[idx]) begin
                win      = idx;
                winFound = 1'b1;
            end
        end
    end

    // New grant only from idle, not disabled, and never on a release edge.
    assign arbGo = IDLE_CYCLE & ~grantHeld & ~ctrlDisable & ~serviceDone & winFound;

    // Grant FSM next-state: idle waits for a winner, hold waits for release.
    always_comb begin
        stateNext    = state;
        validNext    = VALID_DREQ;
        activeChNext = activeCh;
        lowPriNext   = lowPri;
        case (state)
            ArbIdle: begin
                if (arbGo) begin
                    stateNext    = ArbHold;
                    validNext    = 4'b0001 << win;
                    activeChNext = win;
                end
            end
            ArbHold: begin
                if (serviceDone) begin
                    stateNext = ArbIdle;
                    validNext = '0;
                    if (rotatePri) lowPriNext = activeCh;
                end
            end
            default: begin
                stateNext = ArbIdle;
                validNext = '0;
            end
        endcase
    end

    // Grant FSM state register; lowPri=3 makes ch0 first after reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= ArbIdle;
            VALID_DREQ <= '0;
            activeCh   <= '0;
            lowPri     <= 2'd3;
        end else begin
            state      <= stateNext;
            VALID_DREQ <= validNext;
            activeCh   <= activeChNext;
            lowPri     <= lowPriNext;
        end
    end

    // Per-channel DACK level: active only for the held channel while the FSM
    // requests acknowledge, so at most one pin is ever active.
    for (genvar c = 0; c < NCH; c++) begin : gDack
        assign dackNext[c] = (validDACK & grantHeld & (activeCh == 2'(c))) ^ ~dackActHigh;
    end

    // Registered DACK pins; reset drives all high regardless of polarity.
    always_ff @(posedge CLK) begin
        if (RESET) DACK <= '1;
        else       DACK <= dackNext;
    end

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed bench for dma_priority_arbiter with hand-computed expectations.
module tb_dma_priority_arbiter;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] DREQ;
    logic [7:0] commandReg;
    logic [3:0] maskReg;
    logic [3:0] requestReg;
    logic       IDLE_CYCLE;
    logic       validDACK;
    logic       serviceDone;
    logic [3:0] VALID_DREQ;
    logic [3:0] DACK;
    logic [1:0] activeCh;
    logic [3:0] reqStatus;

    int nTests = 0;
    int nFail  = 0;

    dma_priority_arbiter #(.NCH(4)) dut (
        .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .commandReg(commandReg),
        .maskReg(maskReg), .requestReg(requestReg), .IDLE_CYCLE(IDLE_CYCLE),
        .validDACK(validDACK), .serviceDone(serviceDone),
        .VALID_DREQ(VALID_DREQ), .DACK(DACK), .activeCh(activeCh),
        .reqStatus(reqStatus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic doReset(input logic [7:0] cmd, input logic [3:0] dreq);
        RESET = 1'b1; commandReg = cmd; DREQ = dreq; maskReg = '0;
        requestReg = '0; IDLE_CYCLE = 1'b1; validDACK = 1'b0; serviceDone = 1'b0;
        tick();
        RESET = 1'b0;
    endtask

    task automatic release1();
        serviceDone = 1'b1;
        tick();
        serviceDone = 1'b0;
    endtask

    initial begin
        logic [3:0] rotExp [5];
        rotExp[0] = 4'b0001; rotExp[1] = 4'b0010; rotExp[2] = 4'b0100;
        rotExp[3] = 4'b1000; rotExp[4] = 4'b0001;

        // ---------------- reset state and fixed priority
        doReset(8'h00, 4'b0000);
        chk("rst_valid", {4'b0, VALID_DREQ}, 8'h00);
        chk("rst_ch",    {6'b0, activeCh},   8'h00);
        chk("rst_stat",  {4'b0, reqStatus},  8'h00);
        chk("rst_dack",  {4'b0, DACK},       8'h0F);
        DREQ = 4'b1010;
        tick();
        chk("fix_lat1",  {4'b0, VALID_DREQ}, 8'h00);
        tick();
        chk("fix_grant", {4'b0, VALID_DREQ}, 8'h02);
        chk("fix_ch",    {6'b0, activeCh},   8'h01);
        chk("fix_stat",  {4'b0, reqStatus},  8'h0A);
        validDACK = 1'b1;
        tick();
        chk("fix_dack",  {4'b0, DACK},       8'h0D);
        validDACK = 1'b0;
        DREQ = 4'b1000;
        tick();
        chk("fix_dack_off", {4'b0, DACK},    8'h0F);
        tick();
        chk("fix_hold",  {4'b0, VALID_DREQ}, 8'h02);
        release1();
        chk("fix_rel",   {4'b0, VALID_DREQ}, 8'h00);
        tick();
        chk("fix_next",  {4'b0, VALID_DREQ}, 8'h08);
        chk("fix_next_ch", {6'b0, activeCh}, 8'h03);

        // ---------------- rotating priority, DREQ all held
        doReset(8'h10, 4'b1111);
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rot_grant%0d", k), {4'b0, VALID_DREQ}, {4'b0, rotExp[k]});
            if (k < 4) begin
                release1();
                chk($sformatf("rot_rel%0d", k), {4'b0, VALID_DREQ}, 8'h00);
                tick();
            end
        end

        // ---------------- mask, software request, status
        doReset(8'h00, 4'b0001);
        maskReg = 4'b0001; requestReg = 4'b0100;
        tick();
        chk("sw_grant",  {4'b0, VALID_DREQ}, 8'h04);
        tick();
        chk("sw_hold",   {4'b0, VALID_DREQ}, 8'h04);
        chk("sw_stat",   {4'b0, reqStatus},  8'h05);
        requestReg = 4'b0000;
        release1();
        tick();
        tick();
        chk("mask_block", {4'b0, VALID_DREQ}, 8'h00);
        chk("mask_stat",  {4'b0, reqStatus},  8'h01);

        // ---------------- polarities
        doReset(8'hC0, 4'b1110);
        tick();
        tick();
        chk("pol_grant", {4'b0, VALID_DREQ}, 8'h01);
        chk("pol_dack_idle", {4'b0, DACK},   8'h00);
        validDACK = 1'b1;
        tick();
        chk("pol_dack_act", {4'b0, DACK},    8'h01);
        validDACK = 1'b0;
        tick();
        chk("pol_dack_off", {4'b0, DACK},    8'h00);

        // ---------------- hold and controller disable
        doReset(8'h00, 4'b0010);
        tick();
        tick();
        chk("hold_grant", {4'b0, VALID_DREQ}, 8'h02);
        DREQ = 4'b0000; maskReg = 4'hF; commandReg = 8'h14;
        tick();
        tick();
        chk("hold_keep",  {4'b0, VALID_DREQ}, 8'h02);
        chk("hold_ch",    {6'b0, activeCh},   8'h01);
        release1();
        chk("hold_rel",   {4'b0, VALID_DREQ}, 8'h00);
        maskReg = 4'h0; DREQ = 4'b1111;
        tick();
        tick();
        tick();
        chk("dis_nogrant", {4'b0, VALID_DREQ}, 8'h00);
        chk("dis_stat",    {4'b0, reqStatus},  8'h0F);
        commandReg = 8'h00;
        tick();
        chk("dis_clear",   {4'b0, VALID_DREQ}, 8'h01);

        // ---------------- reset mid-service (rotating, ch2 held)
        doReset(8'h10, 4'b1111);
        tick();
        tick();
        release1();
        tick();
        release1();
        tick();
        chk("mid_ch2",   {4'b0, VALID_DREQ}, 8'h04);
        validDACK = 1'b1;
        tick();
        chk("mid_dack",  {4'b0, DACK},       8'h0B);
        RESET = 1'b1;
        tick();
        RESET = 1'b0; validDACK = 1'b0;
        chk("mid_valid", {4'b0, VALID_DREQ}, 8'h00);
        chk("mid_dackF", {4'b0, DACK},       8'h0F);
        chk("mid_stat",  {4'b0, reqStatus},  8'h00);
        chk("mid_ch",    {6'b0, activeCh},   8'h00);
        tick();
        tick();
        chk("mid_rearb", {4'b0, VALID_DREQ}, 8'h01);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
